hsync_tx_feeder: RTL and testbench

//  Source-domain stage directly upstream of the hsync sender. Buffers bytes from a

---
 rtl/hsync_tx_feeder_if.sv | 23 ++
 rtl/hsync_tx_feeder.sv | 163 ++++++++++++++++
 tb/tb_hsync_tx_feeder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hsync_tx_feeder_if.sv
// Producer-side valid/ready bus plus the start/dout/ready link into the hsync sender.
interface hsync_tx_feeder_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          start;
  logic [DW-1:0] dout;
  logic          ready;

  // Environment side: producer and sender.
  modport master (
    output in_valid, in_data, ready,
    input  in_ready, start, dout
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_data, ready,
    output in_ready, start, dout
  );
endinterface

// File: rtl/hsync_tx_feeder.sv
// hsync_tx_feeder: buffers producer bytes in a small FIFO and launches one
// start/dout transfer per byte into the hsync sender, pacing on its ready.
// Counts completed transfers and raises a sticky error on a ready timeout.
module hsync_tx_feeder #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int TMO   = 255
) (
  input  logic                clk_s,
  input  logic                reset_s,
  hsync_tx_feeder_if.slave    bus,
  output logic [AW:0]         level,
  output logic                busy,
  output logic [15:0]         xfer_cnt,
  output logic                err
);

  localparam int unsigned TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [TW-1:0] tmo_q;
  logic [DW-1:0] dout_q;
  logic          start_q;
  logic [15:0]   xfer_cnt_q;
  logic          err_q;

  logic full;
  logic push;
  logic pop;
  logic launch;
  logic timeout;
  logic tmo_clr;
  logic tmo_inc;
  logic tmo_hit;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign push    = bus.in_valid && !full;
  assign tmo_hit = (tmo_q == TW'(TMO));

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    launch  = 1'b0;
    timeout = 1'b0;
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0 && bus.ready) begin
          state_d = LAUNCH;
          launch  = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_LO;
        tmo_clr = 1'b1;
      end
      WAIT_LO: begin
        if (!bus.ready) begin
          state_d = WAIT_HI;
          tmo_clr = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          timeout = 1'b1;
          tmo_clr = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WAIT_HI: begin
        if (bus.ready) begin
          state_d = IDLE;
          pop     = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          timeout = 1'b1;
          tmo_clr = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, launch pulse, held output byte, timeout counter and status.
  always_ff @(posedge clk_s) begin
    if (!reset_s) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      dout_q     <= '0;
      tmo_q      <= '0;
      xfer_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == LAUNCH);
      if (launch) begin
        dout_q <= mem[rd_ptr_q];
      end
      if (tmo_clr) begin
        tmo_q <= '0;
      end else if (tmo_inc) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (pop) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; a pop never frees room for a same-cycle push.
  always_ff @(posedge clk_s) begin
    if (!reset_s) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_s) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready = !full;
  assign bus.start    = start_q;
  assign bus.dout     = dout_q;
  assign level        = level_q;
  assign busy         = (state_q != IDLE);
  assign xfer_cnt     = xfer_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_hsync_tx_feeder.sv
// Testbench for hsync_tx_feeder: directed phases plus random traffic against a
// queue-based reference model, with a randomized hsync sender on ready.
module tb_hsync_tx_feeder;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TMO   = 255;

  logic        clk_s   = 1'b0;
  logic        reset_s = 1'b0;
  logic [AW:0] level;
  logic        busy;
  logic [15:0] xfer_cnt;
  logic        err;

  hsync_tx_feeder_if #(.DW(DW)) bif ();

  hsync_tx_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
    .clk_s    (clk_s),
    .reset_s  (reset_s),
    .bus      (bif),
    .level    (level),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .err      (err)
  );

  always #5 clk_s = ~clk_s;

  // Reference model: queue of accepted bytes, transfer phase, counters.
  logic [DW-1:0] sb_q[$];
  int            ph;        // 0 idle, 1 launch cycle, 2 awaiting ready low, 3 awaiting ready high
  int            wc;        // stalled cycles in the current wait
  logic [15:0]   m_cnt;
  bit            m_err;
  logic [DW-1:0] m_dout;
  bit            armed;
  bit            m_pop;
  int            m_sz;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            smode    = 0; // 0 random sender, 1 ready stuck high, 2 ready held low, 3 long low phase

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model by one edge.
  always @(negedge clk_s) begin
    if (armed) begin
      chk("level",    32'(level),        32'(sb_q.size()));
      chk("in_ready", 32'(bif.in_ready), 32'(sb_q.size() < DEPTH));
      chk("busy",     32'(busy),         32'(ph != 0));
      chk("start",    32'(bif.start),    32'(ph == 1));
      chk("dout",     32'(bif.dout),     32'(m_dout));
      chk("xfer_cnt", 32'(xfer_cnt),     32'(m_cnt));
      chk("err",      32'(err),          32'(m_err));
    end
    if (!reset_s) begin
      sb_q.delete();
      ph     = 0;
      wc     = 0;
      m_cnt  = '0;
      m_err  = 1'b0;
      m_dout = '0;
      armed  = 1'b1;
    end else if (armed) begin
      m_pop = 1'b0;
      m_sz  = sb_q.size();
      case (ph)
        0: if (m_sz > 0 && bif.ready) begin ph = 1; m_dout = sb_q[0]; end
        1: begin ph = 2; wc = 0; end
        2: begin
          if (!bif.ready) begin ph = 3; wc = 0; end
          else if (wc == TMO) begin ph = 0; m_err = 1'b1; end
          else wc++;
        end
        default: begin
          if (bif.ready) begin ph = 0; m_pop = 1'b1; end
          else if (wc == TMO) begin ph = 0; m_err = 1'b1; end
          else wc++;
        end
      endcase
      if (bif.in_valid && m_sz < DEPTH) sb_q.push_back(bif.in_data);
      if (m_pop) begin
        void'(sb_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
    end
  end

  // Sender model: after start, ready stays high 1..3 cycles, then low for a while, then high.
  initial begin : sender
    int hi_left, lo_left, lo_len;
    hi_left = 0; lo_left = 0; lo_len = 0;
    bif.ready = 1'b1;
    forever begin
      @(posedge clk_s); #1;
      if (smode == 1 || smode == 2) begin
        hi_left = 0; lo_left = 0;
        bif.ready = (smode == 1);
      end else begin
        if (bif.start && hi_left == 0 && lo_left == 0) begin
          hi_left = $urandom_range(1, 3);
          lo_len  = (smode == 3) ? 20 : $urandom_range(1, 6);
        end
        if (hi_left > 0) begin
          bif.ready = 1'b1;
          hi_left--;
          if (hi_left == 0) lo_left = lo_len;
        end else if (lo_left > 0) begin
          bif.ready = 1'b0;
          lo_left--;
        end else begin
          bif.ready = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_s); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic push(input logic [DW-1:0] d);
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    cyc();
    bif.in_valid = 1'b0;
  endtask

  // Stimulus.
  initial begin : driver
    int k;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    reset_s = 1'b0;
    idle(3);
    reset_s = 1'b1;
    idle(2);

    // Single byte through a normal handshake.
    push(8'hA5);
    idle(20);

    // Fill while the sender is busy: fifth byte refused, then drain in order.
    smode = 2;
    for (int i = 1; i <= 5; i++) push(8'(i));
    smode = 0;
    idle(60);

    // Sender never acknowledges: timeout, retry of the same byte.
    smode = 1;
    push(8'h3C);
    idle(2 * (TMO + 4) + 10);
    smode = 0;
    idle(TMO + 40);

    // Full FIFO with pushes continuing while transfers complete.
    smode = 2;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    smode = 0;
    bif.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bif.in_data = 8'($urandom);
      cyc();
    end
    bif.in_valid = 1'b0;
    idle(60);

    // Random producer traffic.
    for (int i = 0; i < 400; i++) begin
      bif.in_valid = 1'($urandom_range(0, 1));
      bif.in_data  = 8'($urandom);
      cyc();
    end
    bif.in_valid = 1'b0;
    idle(60);

    // Reset while awaiting the sender's final ready rise with bytes queued.
    smode = 2;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
    smode = 3;
    k = 0;
    while (ph != 3 && k < 50) begin
      cyc();
      k++;
    end
    chk("reach_wait_hi", 32'(k < 50), 32'd1);
    reset_s = 1'b0;
    idle(2);
    reset_s = 1'b1;
    smode = 0;
    idle(40);

    // Transfer counter wraps from 0xFFFF to 0.
    force dut.xfer_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cyc();
    release dut.xfer_cnt_q;
    push(8'h77);
    idle(20);
    chk("wrap_cnt", 32'(xfer_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
